// File: rtl/ip_matrix_axil_pkg.sv
// ---------------------------------------------------------------------------
// ip_matrix_axil_pkg
// Shared definitions for the IP_MATRIX AXI4-Lite register slave:
//   AXI_RESP_OKAY - the only response code this slave ever returns
//   wr_state_t    - write channel FSM states (address/data may arrive in
//                   either order)
//   rd_state_t    - read channel FSM states
//   strb_merge    - byte-lane merge of new write data into a 32-bit register
// ---------------------------------------------------------------------------
package ip_matrix_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ip_matrix_axil_slave.sv
// ---------------------------------------------------------------------------
// ip_matrix_axil_slave
// AXI4-Lite responder holding NUM_REGS 32-bit software registers for the
// IP_MATRIX datapath. Single-beat reads and writes, byte strobes honoured,
// every response is OKAY.
//
// Ports:
//   ACLK, ARESET              clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*      write address / write data channels
//   S_AXI_B*                  write response channel
//   S_AXI_AR* / S_AXI_R*      read address / read data channels
//   reg_out                   all registers, reg i at [i*DATA_W +: DATA_W]
//   reg_wr_pulse              bit i high for one cycle after reg i is written
// ---------------------------------------------------------------------------
module ip_matrix_axil_slave
  import ip_matrix_axil_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  localparam int NUM_REGS = 2 ** (ADDR_W - 2),
  localparam int STRB_W   = DATA_W / 8,
  localparam int IDX_W    = ADDR_W - 2
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [STRB_W-1:0]            S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  wr_state_t           wr_state_q, wr_state_d;
  rd_state_t           rd_state_q, rd_state_d;
  logic [IDX_W-1:0]    aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                aw_hs, w_hs, ar_hs;
  logic                commit;
  logic [IDX_W-1:0]    commit_idx;
  logic [DATA_W-1:0]   commit_data;
  logic [STRB_W-1:0]   commit_strb;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // READY/VALID come straight from state flops; reset forces the READYs low.
  assign S_AXI_AWREADY = !ARESET && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_W);
  assign S_AXI_WREADY  = !ARESET && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_AW);
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = !ARESET && (rd_state_q == RD_IDLE);
  assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_wr_pulse  = wr_pulse_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
    assign reg_out[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

  // Write channel: whichever of AW/W arrives first is parked; the register
  // update happens on the edge where the second one completes. Live bus
  // values are used for the half that completes on that edge.
  always_comb begin
    wr_state_d  = wr_state_q;
    aw_idx_d    = aw_idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    regs_d      = regs_q;
    wr_pulse_d  = '0;
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;

    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_idx  = S_AXI_AWADDR[ADDR_W-1:2];
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
        end else if (aw_hs) begin
          aw_idx_d   = S_AXI_AWADDR[ADDR_W-1:2];
          wr_state_d = WR_HAVE_AW;
        end else if (w_hs) begin
          wdata_d    = S_AXI_WDATA;
          wstrb_d    = S_AXI_WSTRB;
          wr_state_d = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = S_AXI_WDATA;
          commit_strb = S_AXI_WSTRB;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs) begin
          commit     = 1'b1;
          commit_idx = S_AXI_AWADDR[ADDR_W-1:2];
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    if (commit) begin
      regs_d[commit_idx]     = strb_merge(regs_q[commit_idx], commit_data, commit_strb);
      wr_pulse_d[commit_idx] = 1'b1;
      wr_state_d             = WR_RESP;
    end
  end

  // Read channel: data is captured from the register array as it stood
  // before this edge, so a write landing on the same edge is not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rdata_d    = regs_q[S_AXI_ARADDR[ADDR_W-1:2]];
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (S_AXI_RREADY) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ip_matrix_axil_slave.sv
// ---------------------------------------------------------------------------
// tb_ip_matrix_axil_slave
// Scoreboard bench for the IP_MATRIX AXI4-Lite slave. The driver issues
// directed and random transactions and pushes the expected read data,
// register snapshot and write pulse into queues; an independent monitor
// pops and compares whenever the DUT completes a B/R handshake or pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ip_matrix_axil_slave;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 4;

  logic                       ACLK = 1'b0;
  logic                       ARESET;
  logic [ADDR_W-1:0]          S_AXI_AWADDR;
  logic [2:0]                 S_AXI_AWPROT;
  logic                       S_AXI_AWVALID;
  logic                       S_AXI_AWREADY;
  logic [DATA_W-1:0]          S_AXI_WDATA;
  logic [3:0]                 S_AXI_WSTRB;
  logic                       S_AXI_WVALID;
  logic                       S_AXI_WREADY;
  logic [1:0]                 S_AXI_BRESP;
  logic                       S_AXI_BVALID;
  logic                       S_AXI_BREADY;
  logic [ADDR_W-1:0]          S_AXI_ARADDR;
  logic [2:0]                 S_AXI_ARPROT;
  logic                       S_AXI_ARVALID;
  logic                       S_AXI_ARREADY;
  logic [DATA_W-1:0]          S_AXI_RDATA;
  logic [1:0]                 S_AXI_RRESP;
  logic                       S_AXI_RVALID;
  logic                       S_AXI_RREADY;
  logic [NUM_REGS*DATA_W-1:0] reg_out;
  logic [NUM_REGS-1:0]        reg_wr_pulse;

  always #5 ACLK = ~ACLK;

  ip_matrix_axil_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference register file and scoreboard queues.
  logic [31:0]  model_regs [NUM_REGS];
  logic [31:0]  rd_exp_q [$];
  logic [127:0] wr_exp_q [$];
  logic [3:0]   pulse_exp_q [$];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: event did not occur as required", name);
  endtask

  function automatic logic [127:0] modelSnapshot();
    logic [127:0] snap;
    for (int i = 0; i < NUM_REGS; i++) snap[i*32 +: 32] = model_regs[i];
    return snap;
  endfunction

  // Mask-based byte update of the reference register.
  function automatic void modelWrite(input int idx, input logic [31:0] data,
                                     input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
    model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
  endfunction

  // Monitor: compares whenever the DUT completes a response or pulses.
  always @(negedge ACLK) begin
    if (ARESET === 1'b0) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        checkOutput("bresp", S_AXI_BRESP, 2'b00);
        if (wr_exp_q.size() == 0) failNow("unexpected_b_response");
        else checkOutput("reg_out_at_b", reg_out, wr_exp_q.pop_front());
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        checkOutput("rresp", S_AXI_RRESP, 2'b00);
        if (rd_exp_q.size() == 0) failNow("unexpected_r_response");
        else checkOutput("rdata", S_AXI_RDATA, rd_exp_q.pop_front());
      end
      if (reg_wr_pulse !== 4'b0000) begin
        if (pulse_exp_q.size() == 0) failNow("unexpected_wr_pulse");
        else checkOutput("reg_wr_pulse", reg_wr_pulse, pulse_exp_q.pop_front());
      end
    end
  end

  // Write driver. Tasks start and end just after a rising edge.
  task automatic applyWrite(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, input bit pending);
    int cyc;
    int idx;
    bit aw_done, w_done, aw_fire, w_fire, done;
    idx = int'(addr >> 2);
    aw_done = 0; w_done = 0; cyc = 0;
    S_AXI_AWADDR = addr;
    S_AXI_AWPROT = 3'($urandom);
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done && cyc >= aw_dly) S_AXI_AWVALID = 1'b1;
      if (!w_done && cyc >= w_dly) S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      if (aw_done && !w_done) begin
        checkOutput("awready_have_aw", S_AXI_AWREADY, 1'b0);
        checkOutput("wready_have_aw", S_AXI_WREADY, 1'b1);
      end
      if (w_done && !aw_done) begin
        checkOutput("awready_have_w", S_AXI_AWREADY, 1'b1);
        checkOutput("wready_have_w", S_AXI_WREADY, 1'b0);
      end
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_fire) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_fire) begin w_done = 1; S_AXI_WVALID = 1'b0; end
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      failNow("write_handshake_timeout");
      return;
    end
    modelWrite(idx, data, strb);
    pulse_exp_q.push_back(4'b0001 << idx);
    if (pending) begin
      @(negedge ACLK);
      checkOutput("bvalid_pending", S_AXI_BVALID, 1'b1);
      @(posedge ACLK); #1;
      return;
    end
    wr_exp_q.push_back(modelSnapshot());
    S_AXI_BREADY = (b_dly == 0);
    done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge ACLK);
      checkOutput("bvalid_held", S_AXI_BVALID, 1'b1);
      if (!S_AXI_BREADY) begin
        checkOutput("awready_during_b", S_AXI_AWREADY, 1'b0);
        checkOutput("wready_during_b", S_AXI_WREADY, 1'b0);
      end
      done = S_AXI_BVALID && S_AXI_BREADY;
      @(posedge ACLK); #1;
      cyc++;
      if (cyc >= b_dly) S_AXI_BREADY = 1'b1;
    end
    S_AXI_BREADY = 1'b0;
    if (!done) begin
      failNow("b_handshake_timeout");
      return;
    end
    @(negedge ACLK);
    checkOutput("awready_after_b", S_AXI_AWREADY, 1'b1);
    checkOutput("wready_after_b", S_AXI_WREADY, 1'b1);
    @(posedge ACLK); #1;
  endtask

  // Read driver; the expected data is supplied by the caller from the model.
  task automatic applyRead(input logic [3:0] addr, input int r_dly,
                           input logic [31:0] exp, input bit pending);
    int cyc;
    bit fired, done;
    S_AXI_ARADDR  = addr;
    S_AXI_ARPROT  = 3'($urandom);
    S_AXI_ARVALID = 1'b1;
    fired = 0; cyc = 0;
    while (!fired && cyc < 50) begin
      @(negedge ACLK);
      fired = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!fired) begin
      failNow("ar_handshake_timeout");
      return;
    end
    if (pending) begin
      @(negedge ACLK);
      checkOutput("rvalid_pending", S_AXI_RVALID, 1'b1);
      @(posedge ACLK); #1;
      return;
    end
    rd_exp_q.push_back(exp);
    S_AXI_RREADY = (r_dly == 0);
    done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge ACLK);
      checkOutput("rvalid_held", S_AXI_RVALID, 1'b1);
      if (!S_AXI_RREADY) begin
        checkOutput("arready_during_r", S_AXI_ARREADY, 1'b0);
        checkOutput("rdata_stable", S_AXI_RDATA, exp);
      end
      done = S_AXI_RVALID && S_AXI_RREADY;
      @(posedge ACLK); #1;
      cyc++;
      if (cyc >= r_dly) S_AXI_RREADY = 1'b1;
    end
    S_AXI_RREADY = 1'b0;
    if (!done) failNow("r_handshake_timeout");
  endtask

  // Random write followed by a random read, checked against the model.
  task automatic applyStimulus(input int iterations);
    logic [3:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    for (int n = 0; n < iterations; n++) begin
      waddr = 4'($urandom_range(0, 15));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      applyWrite(waddr, wdata, wstrb, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), 1'b0);
      raddr = 4'($urandom_range(0, 15));
      applyRead(raddr, $urandom_range(0, 2), model_regs[int'(raddr >> 2)], 1'b0);
    end
  endtask

  task automatic checkIdleAfterReset(input string tag);
    checkOutput({tag, "_bvalid"}, S_AXI_BVALID, 1'b0);
    checkOutput({tag, "_rvalid"}, S_AXI_RVALID, 1'b0);
    checkOutput({tag, "_awready"}, S_AXI_AWREADY, 1'b0);
    checkOutput({tag, "_wready"}, S_AXI_WREADY, 1'b0);
    checkOutput({tag, "_arready"}, S_AXI_ARREADY, 1'b0);
    checkOutput({tag, "_rdata"}, S_AXI_RDATA, 32'h0);
    checkOutput({tag, "_reg_out"}, reg_out, 128'h0);
    checkOutput({tag, "_wr_pulse"}, reg_wr_pulse, 4'h0);
  endtask

  task automatic checkReadyAfterReset(input string tag);
    checkOutput({tag, "_awready"}, S_AXI_AWREADY, 1'b1);
    checkOutput({tag, "_wready"}, S_AXI_WREADY, 1'b1);
    checkOutput({tag, "_arready"}, S_AXI_ARREADY, 1'b1);
  endtask

  initial begin
    logic [31:0] pre_val;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    modelReset();

    repeat (2) @(posedge ACLK);
    #1;
    checkIdleAfterReset("por");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    checkReadyAfterReset("por_release");

    // Basic write then read-back of every register.
    for (int i = 0; i < NUM_REGS; i++)
      applyWrite(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, 1'b0);
    for (int i = 0; i < NUM_REGS; i++)
      applyRead(4'(i * 4), 0, 32'(i + 1), 1'b0);

    // Partial strobe merge.
    applyWrite(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1'b0);
    applyWrite(4'h0, 32'h1234_5678, 4'b0101, 0, 0, 0, 1'b0);
    applyRead(4'h0, 0, 32'hFF34_FF78, 1'b0);

    // Address three cycles ahead of data, then data ahead of address.
    applyWrite(4'h8, 32'h0000_00A5, 4'hF, 0, 3, 0, 1'b0);
    applyRead(4'h8, 1, 32'h0000_00A5, 1'b0);
    applyWrite(4'hC, 32'hCAFE_0004, 4'hF, 2, 0, 1, 1'b0);

    // Strobe of zero: no data change but still a response and a pulse.
    applyWrite(4'h8, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 1'b0);
    applyRead(4'h8, 0, 32'h0000_00A5, 1'b0);

    // Response back-pressure, then an immediate follow-on write.
    applyWrite(4'h4, 32'h0000_0002, 4'hF, 0, 0, 5, 1'b0);
    applyWrite(4'hE, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 1'b0);

    // Write and read of the same register on the same edge.
    pre_val = model_regs[1];
    fork
      applyWrite(4'h4, 32'h0000_BEEF, 4'hF, 0, 0, 0, 1'b0);
      applyRead(4'h4, 0, pre_val, 1'b0);
    join
    applyRead(4'h4, 0, 32'h0000_BEEF, 1'b0);

    applyStimulus(30);

    // Reset with a write response and read data both outstanding.
    applyWrite(4'h0, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b1);
    applyRead(4'h4, 0, model_regs[1], 1'b1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checkIdleAfterReset("mid_reset");
    modelReset();
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    checkReadyAfterReset("mid_release");
    applyRead(4'h0, 0, 32'h0, 1'b0);
    applyWrite(4'h4, 32'h5555_AAAA, 4'b0011, 1, 0, 0, 1'b0);
    applyRead(4'h4, 0, 32'h0000_AAAA, 1'b0);

    repeat (2) @(posedge ACLK);
    checkOutput("rd_queue_drained", rd_exp_q.size(), 0);
    checkOutput("wr_queue_drained", wr_exp_q.size(), 0);
    checkOutput("pulse_queue_drained", pulse_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
